and_reduce_serial: RTL
======================

Name: and_reduce_serial

Overview:
- Bit-serial AND-reduction engine: accepts a W-bit word through a start/ready handshake, then folds it one bit per clock into a running AND (acc = acc & bit, LSB first).
- Reports the registered result y, the index of the lowest zero bit, and a one-cycle done_tick.
- Serves as the time-multiplexed counterpart of the combinational gate-level reduction blocks, for wide words where a full AND tree is not wanted.
- Drives the board LED/seven-segment status logic in the Ch. 5–6 labs.

Parameters:
- W, 8, input word width; legal range W >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request to load din; accepted only when ready=1.
- din  input  W  word to reduce; sampled on the accepting edge only.
- ready  output  1  high only in IDLE; decoded from state.
- busy  output  1  high in SHIFT and DONE; equals ~ready.
- done_tick  output  1  one-cycle pulse in the DONE state.
- y  output  1  registered AND of all W bits of the last accepted word.
- zero_idx  output  $clog2(W+1)  index of the lowest zero bit; W if no zero bit.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, y=0, zero_idx=0, done_tick=0, ready=1.
  - Internal acc, shift register, count and found flag are cleared.
  - Reset overrides everything, including mid-SHIFT; no done_tick follows an aborted run.
- State IDLE:
  - If start=1, on the clock edge (cycle 0): sreg<=din, acc<=1, cnt<=0, found<=0; go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT, one bit per cycle:
  - acc<=acc & sreg[0]; sreg<=sreg>>1; cnt<=cnt+1.
  - If sreg[0]=0 and found=0: zero_idx_next<=cnt, found<=1.
  - When cnt==W-1, go to DONE.
- State DONE:
  - done_tick=1 for exactly this one cycle.
  - y and zero_idx are updated on the edge that enters DONE. zero_idx is W when found=0.
  - Both outputs hold until the next run's DONE.
  - Next state is IDLE unconditionally.
- Latency: the accepting edge is cycle 0. Bit k is processed in cycle k+1, and done_tick is high in cycle W+1. The next start can be accepted at the earliest in cycle W+2.
- start while busy is ignored; din is not re-sampled.
- cnt width is $clog2(W). The terminal compare is exact, so there is no wrap-around.
- All outputs are registered except ready and busy. No combinational path from start to any output other than through state.

Optional Feature:
- Macro: AND_REDUCE_EARLY_EXIT_EN.
- Defined: in SHIFT, a zero bit moves the FSM directly to DONE on that edge, with y=0 and zero_idx=cnt. done_tick then occurs in cycle k+2, where k is the lowest zero index. An all-ones word still takes W+1 cycles.
- Undefined: fixed W+1 cycle latency regardless of data. y and zero_idx values are identical in both builds.

Decomposition:
- Shared package and_reduce_pkg holds:
  - state typedef: IDLE, SHIFT, DONE, 2-bit encoding.
  - localparam helpers CNT_W=$clog2(W) and IDX_W=$clog2(W+1).
- The Verilog build duplicates these as localparams.
- No sub-module: the FSM, shift register and counter fit in a single module.

Test Plan:
- W=8, din=8'hFF, start pulse -> done_tick high exactly in cycle 9; y=1, zero_idx=8; ready returns to 1 in cycle 10.
- W=8, din=8'hF7 -> y=0, zero_idx=3. done_tick in cycle 9 without the macro; in cycle 5 with AND_REDUCE_EARLY_EXIT_EN.
- W=8, din=8'h00 -> y=0, zero_idx=0. done_tick in cycle 9, or in cycle 2 with the macro.
- start=1 held through a run with din changing to 8'h00 in cycle 3, original din=8'hFF -> result y=1. The second word is accepted only in cycle 10, once ready=1.
- reset_n=0 in cycle 4 of a run -> next edge: state IDLE, y=0, zero_idx=0, no done_tick afterwards; a fresh start then completes normally.
- Back-to-back words 8'hFF then 8'h7F, start held high -> two done_ticks 10 cycles apart; y=1 then 0, zero_idx=8 then 7.

Source files
------------

// File: rtl/and_reduce_pkg.sv
// Shared types and width helpers for the bit-serial AND-reduction engine.
package and_reduce_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bit counter width: indexes bits 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

  // Zero-index width: must also represent w itself ("no zero bit").
  function automatic int unsigned idx_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/and_reduce_serial.sv
// Bit-serial AND reduction of a W-bit word, LSB first, with lowest-zero index.
// Optional AND_REDUCE_EARLY_EXIT_EN: finish on the first zero bit instead of after W bits.
module and_reduce_serial
  import and_reduce_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned CNT_W = cnt_width(W),
  localparam int unsigned IDX_W = idx_width(W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     din,
  output logic             ready,
  output logic             busy,
  output logic             done_tick,
  output logic             y,
  output logic [IDX_W-1:0] zero_idx
);

  state_e             state;
  logic [W-1:0]       sreg;
  logic               acc;
  logic [CNT_W-1:0]   cnt;
  logic               found;
  logic [IDX_W-1:0]   zidx;
  logic               bit0;
  logic               last;

  assign bit0 = sreg[0];

`ifdef AND_REDUCE_EARLY_EXIT_EN
  // Any zero decides the result, so the remaining bits need not be folded.
  assign last = (cnt == CNT_W'(W - 1)) || !bit0;
`else
  assign last = (cnt == CNT_W'(W - 1));
`endif

  assign ready = (state == StIdle);
  assign busy  = ~ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= StIdle;
      sreg      <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      found     <= 1'b0;
      zidx      <= '0;
      done_tick <= 1'b0;
      y         <= 1'b0;
      zero_idx  <= '0;
    end else begin
      done_tick <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            sreg  <= din;
            acc   <= 1'b1;
            cnt   <= '0;
            found <= 1'b0;
            state <= StShift;
          end
        end
        StShift: begin
          acc  <= acc & bit0;
          sreg <= sreg >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (!bit0 && !found) begin
            zidx  <= IDX_W'(cnt);
            found <= 1'b1;
          end
          if (last) begin
            state     <= StDone;
            done_tick <= 1'b1;
            y         <= acc & bit0;
            // The current bit may itself be the first zero; fold it in here.
            zero_idx  <= found ? zidx : (bit0 ? IDX_W'(W) : IDX_W'(cnt));
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
